rt_word_loader: RTL and testbench
=================================

Name: rt_word_loader

Overview:
- Sits directly downstream of the Montgomery precompute stage, which produces n0', R mod n and R^2 mod n (r, t).
- Captures the 32-bit r/t words that stage streams out MSB-word first and stores them in two word-addressed register files, LSW at address 0.
- Latches n0'.
- Serves random word reads to the Montgomery multiplier core, with a ready flag and overflow/underflow status.

Parameters:
- DATA_WIDTH, 32, word width of r, t, n0p and the read data.
- ADDR_WIDTH, 5, word address width.
- TOTAL_ADDR, 2**ADDR_WIDTH = 32, words per operand (1024-bit operands).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: clear status and arm for a new load.
- in_valid  in  1  r/t word present this cycle.
- in_r  in  DATA_WIDTH  r word, MSB word first.
- in_t  in  DATA_WIDTH  t word, same order.
- in_n0p  in  DATA_WIDTH  n0'; sampled with the first accepted word.
- rd_addr  in  ADDR_WIDTH  read word address (0 = least significant word).
- rd_r  out  DATA_WIDTH  registered r word at rd_addr.
- rd_t  out  DATA_WIDTH  registered t word at rd_addr.
- n0p  out  DATA_WIDTH  latched n0'.
- busy  out  1  high while in LOAD.
- ready  out  1  high once all 32 words are stored.
- ovf  out  1  sticky: in_valid seen while READY.
- short_load  out  1  sticky: start arrived during LOAD before 32 words.

Behaviour:
- Reset (asynchronous, active-high; clk and rst as named in Ports):
  - state=IDLE, word count cnt=0, write pointer wptr=TOTAL_ADDR-1.
  - rd_r=0, rd_t=0, n0p=0, busy=0, ready=0, ovf=0, short_load=0.
  - Memory contents are not reset and are undefined until written.
- States:
  - IDLE: ignore in_valid. start -> LOAD with cnt=0, wptr=31, ready=0, ovf=0; short_load is cleared.
  - LOAD (busy=1): each cycle with in_valid=1:
    - write in_r to r_mem[wptr] and in_t to t_mem[wptr];
    - on the first word (cnt==0), latch n0p<=in_n0p;
    - then cnt+=1, wptr-=1.
    - When the 32nd word is written (cnt==31 with in_valid): next state READY, ready=1 in the following cycle, busy=0.
    - in_valid=0 cycles are allowed (gaps); no state change.
  - READY (ready=1): memory frozen.
    - in_valid=1 -> ovf<=1 (sticky); data discarded, no write. This absorbs the trailing all-zero word the upstream emits after word 32.
    - start -> LOAD as from IDLE.
- Write pointer: a 5-bit down-counter. It never wraps within a load, because the transition to READY happens at wptr==0.
- start during LOAD (cnt<32): short_load<=1, restart with cnt=0, wptr=31. Previously written words remain until overwritten.
- start and in_valid in the same cycle: start wins, the word is discarded, and the counters are reset.
- Reads:
  - rd_r/rd_t <= r_mem[rd_addr]/t_mem[rd_addr] every cycle; 1-cycle latency in all states.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
  - Read data is meaningful only when ready=1.
- rst mid-LOAD: immediately returns to IDLE and clears all outputs and counters per the reset values above.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then start, then 32 consecutive in_valid words with in_r=0x1000_0000+k and in_t=0x2000_0000+k (k=0..31), in_n0p=0xDEADBEEF on word 0 -> busy 1 for 32 cycles; ready=1 one cycle after the last word; n0p=0xDEADBEEF; reading rd_addr=0 returns rd_r=0x1000001F, rd_t=0x2000001F; rd_addr=31 returns 0x10000000/0x20000000, each one cycle after rd_addr is applied.
2. Same stream with in_valid deasserted on every other cycle -> identical memory image; ready asserts only after the 32nd valid word; busy stays high throughout.
3. After READY, one extra in_valid word of 0x0 -> ovf=1, memory unchanged (rd_addr=5 still returns the original value); a following start clears ovf and ready.
4. start, 10 words, then start again -> short_load=1. Then 32 new words (0xA0+k) -> ready=1, and all addresses hold the new values, including addresses 22..31.
5. Assert rst asynchronously (mid-cycle) after 15 words -> busy, ready and n0p go to 0 without waiting for a clock edge; later in_valid words are ignored in IDLE until start.
6. start and in_valid asserted in the same cycle with word 0xFFFFFFFF, followed by 32 words 0x0 -> 0xFFFFFFFF never appears at any address; ready asserts after the 32 zero words.

Source files
------------

// File: rtl/rt_word_loader.sv
// -----------------------------------------------------------------------------
// rt_word_loader
//
// Captures the r (R mod n) and t (R^2 mod n) word streams produced by the
// Montgomery precompute stage and holds them for the multiplier core.
// The upstream emits words most-significant first, so the write pointer
// counts down from TOTAL_ADDR-1 and the least significant word ends up at
// address 0. n0' is latched together with the first accepted word.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             one-cycle pulse: clear status, arm a new load
//   in_valid          r/t word present this cycle
//   in_r, in_t        r and t words, MSB word first
//   in_n0p            n0', sampled with the first accepted word
//   rd_addr           read word address (0 = least significant word)
//   rd_r, rd_t        registered read data, one cycle after rd_addr
//   n0p               latched n0'
//   busy              high while loading
//   ready             high once all TOTAL_ADDR words are stored
//   ovf               sticky: in_valid seen while ready
//   short_load        sticky: start arrived before a load completed
// -----------------------------------------------------------------------------
module rt_word_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_t,
   input  logic [DATA_WIDTH-1:0] in_n0p,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_r,
   output logic [DATA_WIDTH-1:0] rd_t,
   output logic [DATA_WIDTH-1:0] n0p,
   output logic                  busy,
   output logic                  ready,
   output logic                  ovf,
   output logic                  short_load
);

   localparam int TOTAL_ADDR = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
   logic [DATA_WIDTH-1:0]   n0p_q, n0p_d;
   logic [DATA_WIDTH-1:0]   rd_r_q, rd_r_d;
   logic [DATA_WIDTH-1:0]   rd_t_q, rd_t_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    ovf_q, ovf_d;
   logic                    short_load_q, short_load_d;
   logic                    wr_en;

   logic [DATA_WIDTH-1:0]   r_mem [TOTAL_ADDR];
   logic [DATA_WIDTH-1:0]   t_mem [TOTAL_ADDR];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      wptr_d       = wptr_q;
      n0p_d        = n0p_q;
      ovf_d        = ovf_q;
      short_load_d = short_load_q;
      wr_en        = 1'b0;

      // start always re-arms; it takes priority over a word in the same cycle.
      if (start) begin
         state_d      = S_LOAD;
         cnt_d        = '0;
         wptr_d       = '1;
         ovf_d        = 1'b0;
         short_load_d = (state_q == S_LOAD);
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  wr_en  = 1'b1;
                  if (cnt_q == '0) n0p_d = in_n0p;
                  cnt_d  = cnt_q + ADDR_WIDTH'(1);
                  wptr_d = wptr_q - ADDR_WIDTH'(1);
                  // Last word lands at wptr==0, so the pointer never wraps
                  // into live data.
                  if (cnt_q == ADDR_WIDTH'(TOTAL_ADDR - 1)) state_d = S_READY;
               end
            end
            S_READY: begin
               // Absorbs the trailing word the upstream emits after the last one.
               if (in_valid) ovf_d = 1'b1;
            end
            default: ;
         endcase
      end

      // Status flags follow the next state so they are registered, not decoded.
      busy_d  = (state_d == S_LOAD);
      ready_d = (state_d == S_READY);

      rd_r_d  = r_mem[rd_addr];
      rd_t_d  = t_mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their _d values from the same pre-edge snapshot.
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wptr_q       <= '1;
         n0p_q        <= '0;
         rd_r_q       <= '0;
         rd_t_q       <= '0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b0;
         ovf_q        <= 1'b0;
         short_load_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wptr_q       <= wptr_d;
         n0p_q        <= n0p_d;
         rd_r_q       <= rd_r_d;
         rd_t_q       <= rd_t_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         ovf_q        <= ovf_d;
         short_load_q <= short_load_d;
      end
   end

   // NOTE: the word stores carry no reset so they map onto plain RAM; their
   // contents are meaningless until a load has written them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wptr_q] <= in_r;
         t_mem[wptr_q] <= in_t;
      end
   end

   assign rd_r       = rd_r_q;
   assign rd_t       = rd_t_q;
   assign n0p        = n0p_q;
   assign busy       = busy_q;
   assign ready      = ready_q;
   assign ovf        = ovf_q;
   assign short_load = short_load_q;

endmodule

// File: tb/tb_rt_word_loader.sv
module tb_rt_word_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [31:0] in_r;
   logic [31:0] in_t;
   logic [31:0] in_n0p;
   logic [4:0]  rd_addr;
   logic [31:0] rd_r;
   logic [31:0] rd_t;
   logic [31:0] n0p;
   logic        busy;
   logic        ready;
   logic        ovf;
   logic        short_load;

   rt_word_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_r       (in_r),
      .in_t       (in_t),
      .in_n0p     (in_n0p),
      .rd_addr    (rd_addr),
      .rd_r       (rd_r),
      .rd_t       (rd_t),
      .n0p        (n0p),
      .busy       (busy),
      .ready      (ready),
      .ovf        (ovf),
      .short_load (short_load)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   // Reference model: the k-th word accepted since the last start is word k
   // of a most-significant-first stream, so it belongs at address 31-k.
   logic [31:0] exp_r [32];
   logic [31:0] exp_t [32];
   bit          known [32];
   logic [31:0] exp_n0p;
   int          pos;

   // Stimulus for one full load.
   logic [31:0] stim_r [32];
   logic [31:0] stim_t [32];
   logic [31:0] stim_n0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      pos   = 0;
   endtask

   // One accepted word; also reads the address being written to confirm the
   // read returns the pre-write contents.
   task automatic drive_word(input logic [31:0] r, input logic [31:0] t, input logic [31:0] n0);
      int          a;
      logic [31:0] old_r;
      bit          was_known;
      a         = 31 - pos;
      old_r     = exp_r[a];
      was_known = known[a];
      in_valid  = 1'b1;
      in_r      = r;
      in_t      = t;
      in_n0p    = n0;
      rd_addr   = 5'(a);
      tick();
      in_valid  = 1'b0;
      if (pos == 0) exp_n0p = n0;
      exp_r[a]  = r;
      exp_t[a]  = t;
      known[a]  = 1'b1;
      pos++;
      if (was_known) check("read_before_write", rd_r, old_r);
   endtask

   // gap: 0 = back-to-back, 1 = idle cycle between words, 2 = random idles.
   task automatic load(input int gap, input bit with_start);
      if (with_start) do_start();
      for (int k = 0; k < 32; k++) begin
         if ((gap == 1 && k > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_r     = $urandom;
            in_t     = $urandom;
            tick();
         end
         check("busy_during_load", 32'(busy), 32'd1);
         check("ready_during_load", 32'(ready), 32'd0);
         drive_word(stim_r[k], stim_t[k], (k == 0) ? stim_n0 : 32'($urandom));
      end
      check("ready_after_load", 32'(ready), 32'd1);
      check("busy_after_load", 32'(busy), 32'd0);
      check("n0p_latched", n0p, exp_n0p);
   endtask

   task automatic verify_all();
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a);
         tick();
         check($sformatf("rd_r[%0d]", a), rd_r, exp_r[a]);
         check($sformatf("rd_t[%0d]", a), rd_t, exp_t[a]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_r     = '0;
      in_t     = '0;
      in_n0p   = '0;
      rd_addr  = '0;
      pos      = 0;
      exp_n0p  = '0;
      for (int i = 0; i < 32; i++) begin
         known[i] = 1'b0;
         exp_r[i] = '0;
         exp_t[i] = '0;
      end

      // Reset values.
      #12;
      check("rst_rd_r", rd_r, 32'd0);
      check("rst_rd_t", rd_t, 32'd0);
      check("rst_n0p", n0p, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_short", 32'(short_load), 32'd0);
      rst = 1'b0;
      tick();

      // 1: back-to-back load of known values.
      for (int k = 0; k < 32; k++) begin
         stim_r[k] = 32'h1000_0000 + 32'(k);
         stim_t[k] = 32'h2000_0000 + 32'(k);
      end
      stim_n0 = 32'hDEAD_BEEF;
      load(0, 1'b1);
      check("t1_n0p", n0p, 32'hDEAD_BEEF);
      rd_addr = 5'd0;
      tick();
      check("t1_rd_r0", rd_r, 32'h1000_001F);
      check("t1_rd_t0", rd_t, 32'h2000_001F);
      rd_addr = 5'd31;
      tick();
      check("t1_rd_r31", rd_r, 32'h1000_0000);
      check("t1_rd_t31", rd_t, 32'h2000_0000);

      // 2: same stream with a gap between every word.
      stim_n0 = 32'h1234_5678;
      load(1, 1'b1);
      verify_all();

      // 3: overflow word while ready, then start clears status.
      in_valid = 1'b1;
      in_r     = '0;
      in_t     = '0;
      tick();
      in_valid = 1'b0;
      check("t3_ovf", 32'(ovf), 32'd1);
      check("t3_ready_kept", 32'(ready), 32'd1);
      rd_addr = 5'd5;
      tick();
      check("t3_rd_r5", rd_r, 32'h1000_001A);
      check("t3_rd_t5", rd_t, 32'h2000_001A);
      do_start();
      check("t3_ovf_clr", 32'(ovf), 32'd0);
      check("t3_ready_clr", 32'(ready), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);

      // 4: ten words then restart; the new full load replaces everything.
      for (int k = 0; k < 10; k++) drive_word($urandom, $urandom, $urandom);
      check("t4_short_pre", 32'(short_load), 32'd0);
      do_start();
      check("t4_short", 32'(short_load), 32'd1);
      for (int k = 0; k < 32; k++) begin
         stim_r[k] = 32'hA0 + 32'(k);
         stim_t[k] = 32'hB0 + 32'(k);
      end
      stim_n0 = 32'hCAFE_0004;
      load(0, 1'b0);
      check("t4_short_sticky", 32'(short_load), 32'd1);
      verify_all();

      // 5: asynchronous reset in the middle of a load.
      do_start();
      check("t5_short_clr", 32'(short_load), 32'd0);
      for (int k = 0; k < 15; k++) drive_word($urandom, $urandom, 32'hFACE_0005);
      check("t5_n0p_pre", n0p, 32'hFACE_0005);
      #2 rst = 1'b1;
      #1;
      check("t5_busy_async", 32'(busy), 32'd0);
      check("t5_ready_async", 32'(ready), 32'd0);
      check("t5_n0p_async", n0p, 32'd0);
      rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_r     = $urandom;
         tick();
         check("t5_idle_busy", 32'(busy), 32'd0);
         check("t5_idle_ready", 32'(ready), 32'd0);
      end
      in_valid = 1'b0;

      // 6: start and a word together; the word is discarded.
      start    = 1'b1;
      in_valid = 1'b1;
      in_r     = 32'hFFFF_FFFF;
      in_t     = 32'hFFFF_FFFF;
      in_n0p   = 32'hFFFF_FFFF;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      pos      = 0;
      check("t6_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 32; k++) begin
         stim_r[k] = '0;
         stim_t[k] = '0;
      end
      stim_n0 = 32'h0000_0006;
      load(0, 1'b0);
      verify_all();

      // 7: random data with random gaps.
      for (int k = 0; k < 32; k++) begin
         stim_r[k] = $urandom;
         stim_t[k] = $urandom;
      end
      stim_n0 = $urandom;
      load(2, 1'b1);
      verify_all();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
